// File: rtl/spi_seq_pkg.sv
// spi_seq_pkg: shared types and constants for the SPI burst sequencer
// Contents: spi_seq_state_t (FSM states), SPI_SEQ_DUMMY (filler byte after the command),
// SPI_SEQ_CNT_W (width of the shared setup/hold/timeout counter).
package spi_seq_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, START, WAIT, STORE, HOLD, DONE} spi_seq_state_t;
  localparam logic [7:0] SPI_SEQ_DUMMY = 8'h00;
  localparam int SPI_SEQ_CNT_W = 8;
endpackage

// File: rtl/spi_seq_contador.sv
// spi_seq_contador: loadable down-counter that stops at zero and flags it
// Ports: clk_pi/rst_n_pi clock and async active-low reset; load_pi loads val_pi (has priority);
// en_pi decrements while nonzero; zero_po is high whenever the count is zero.
module spi_seq_contador #(
  parameter int W = 8
) (
  input  logic         clk_pi,
  input  logic         rst_n_pi,
  input  logic         load_pi,
  input  logic         en_pi,
  input  logic [W-1:0] val_pi,
  output logic         zero_po
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load_pi ? val_pi : (en_pi && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
  always_ff @(posedge clk_pi or negedge rst_n_pi)
    if (!rst_n_pi) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign zero_po = cnt_q == '0;
endmodule

// File: rtl/spi_secuenciador_ctrl.sv
// spi_secuenciador_ctrl: SPI burst sequencer (CS, per-byte start/wait/store, completion)
// Ports: clk_pi, rst_n_pi (async, active-low); inicio_pi/n_bytes_pi/cmd_pi burst request;
// spi_start_po/spi_tx_po/spi_done_pi/spi_rx_pi SPI master handshake; cs_ctrl_po active-low CS;
// we_po/addr_po/wdata_po result memory write; busy_po/done_po/error_po status.
// Optional feature: define SPI_SEQ_TIMEOUT_EN to abort a byte after TIMEOUT cycles in WAIT.
module spi_secuenciador_ctrl
  import spi_seq_pkg::*;
#(
  parameter int ADDR_W   = 2,
  parameter int CS_SETUP = 2,
  parameter int TIMEOUT  = 255
) (
  input  logic              clk_pi,
  input  logic              rst_n_pi,
  input  logic              inicio_pi,
  input  logic [ADDR_W:0]   n_bytes_pi,
  input  logic [7:0]        cmd_pi,
  output logic              spi_start_po,
  output logic [7:0]        spi_tx_po,
  input  logic              spi_done_pi,
  input  logic [7:0]        spi_rx_pi,
  output logic              cs_ctrl_po,
  output logic              we_po,
  output logic [ADDR_W-1:0] addr_po,
  output logic [7:0]        wdata_po,
  output logic              busy_po,
  output logic              done_po,
  output logic              error_po
);
  localparam logic [ADDR_W:0] N_MAX = {1'b1, {ADDR_W{1'b0}}};
  spi_seq_state_t state_q, state_d;
  logic [ADDR_W:0] n_q, n_d;
  logic [7:0] cmd_q, cmd_d, tx_q, tx_d, wdata_q, wdata_d;
  logic [ADDR_W-1:0] idx_q, idx_d, addr_q, addr_d;
  logic cs_q, cs_d, start_q, start_d, we_q, we_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic cnt_load, cnt_en, cnt_zero, last;
  logic [SPI_SEQ_CNT_W-1:0] cnt_val;
  assign last = {1'b0, idx_q} == n_q - 1'b1;
  always_comb begin
    state_d = state_q;
    n_d = n_q;
    cmd_d = cmd_q;
    idx_d = idx_q;
    err_d = err_q;
    wdata_d = '0;
    case (state_q)
      IDLE: if (inicio_pi) begin
        n_d = n_bytes_pi > N_MAX ? N_MAX : n_bytes_pi;
        cmd_d = cmd_pi;
        idx_d = '0;
        err_d = 1'b0;
        state_d = n_bytes_pi == '0 ? DONE : SETUP;
      end
      SETUP: state_d = cnt_zero ? START : SETUP;
      START: state_d = WAIT;
      WAIT: if (spi_done_pi) begin
        wdata_d = spi_rx_pi;
        state_d = STORE;
      end
`ifdef SPI_SEQ_TIMEOUT_EN
      else if (cnt_zero) begin
        err_d = 1'b1;
        state_d = HOLD;
      end
`endif
      STORE: begin
        idx_d = last ? idx_q : idx_q + 1'b1;
        state_d = last ? HOLD : START;
      end
      HOLD: state_d = cnt_zero ? DONE : HOLD;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // Outputs are derived from the next state so every port comes straight from a flop.
  always_comb begin
    cs_d = state_d inside {IDLE, DONE};
    start_d = state_d == START;
    tx_d = start_d ? (idx_d == '0 ? cmd_d : SPI_SEQ_DUMMY) : '0;
    we_d = state_d == STORE;
    addr_d = we_d ? idx_d : '0;
    busy_d = state_d != IDLE;
    done_d = state_d == DONE;
    cnt_load = state_d != state_q && state_d inside {SETUP, WAIT, HOLD};
    cnt_en = state_q inside {SETUP, WAIT, HOLD};
    cnt_val = state_d == WAIT ? SPI_SEQ_CNT_W'(TIMEOUT - 1) : SPI_SEQ_CNT_W'(CS_SETUP - 1);
  end
  spi_seq_contador #(.W(SPI_SEQ_CNT_W)) u_cnt (
    .clk_pi(clk_pi), .rst_n_pi(rst_n_pi), .load_pi(cnt_load), .en_pi(cnt_en),
    .val_pi(cnt_val), .zero_po(cnt_zero)
  );
  always_ff @(posedge clk_pi or negedge rst_n_pi)
    if (!rst_n_pi) begin
      state_q <= IDLE;
      n_q <= '0;
      cmd_q <= '0;
      idx_q <= '0;
      cs_q <= 1'b1;
      start_q <= 1'b0;
      tx_q <= '0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q <= n_d;
      cmd_q <= cmd_d;
      idx_q <= idx_d;
      cs_q <= cs_d;
      start_q <= start_d;
      tx_q <= tx_d;
      we_q <= we_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      busy_q <= busy_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  assign spi_start_po = start_q;
  assign spi_tx_po = tx_q;
  assign cs_ctrl_po = cs_q;
  assign we_po = we_q;
  assign addr_po = addr_q;
  assign wdata_po = wdata_q;
  assign busy_po = busy_q;
  assign done_po = done_q;
  assign error_po = err_q;
endmodule

// File: tb/tb_spi_secuenciador_ctrl.sv
// tb_spi_secuenciador_ctrl: directed bursts checked cycle by cycle against a timeline model
module tb_spi_secuenciador_ctrl;
  localparam int ADDR_W = 2, CS_SETUP = 2, TIMEOUT = 10, NMAX = 4;
  logic clk_pi = 1'b0, rst_n_pi = 1'b0, inicio_pi = 1'b0, spi_done_pi = 1'b0;
  logic [ADDR_W:0] n_bytes_pi = '0;
  logic [7:0] cmd_pi = '0, spi_rx_pi = '0;
  logic spi_start_po, cs_ctrl_po, we_po, busy_po, done_po, error_po;
  logic [7:0] spi_tx_po, wdata_po;
  logic [ADDR_W-1:0] addr_po;
  spi_secuenciador_ctrl #(.ADDR_W(ADDR_W), .CS_SETUP(CS_SETUP), .TIMEOUT(TIMEOUT)) dut (
    .clk_pi(clk_pi), .rst_n_pi(rst_n_pi), .inicio_pi(inicio_pi), .n_bytes_pi(n_bytes_pi),
    .cmd_pi(cmd_pi), .spi_start_po(spi_start_po), .spi_tx_po(spi_tx_po), .spi_done_pi(spi_done_pi),
    .spi_rx_pi(spi_rx_pi), .cs_ctrl_po(cs_ctrl_po), .we_po(we_po), .addr_po(addr_po),
    .wdata_po(wdata_po), .busy_po(busy_po), .done_po(done_po), .error_po(error_po)
  );
  always #5 clk_pi = ~clk_pi;
  int errors = 0, checks = 0;
  logic chk_on = 1'b0;
  int rel = 0;
  logic exp_cs [256], exp_start [256], exp_we [256], exp_busy [256], exp_done [256], exp_err [256];
  logic [7:0] exp_tx [256], exp_wd [256];
  logic [ADDR_W-1:0] exp_addr [256];
  logic drv_done [256], drv_ini [256];
  logic [7:0] drv_rx [256];
  int lat_g [4];
  logic [7:0] rx_g [4];
  logic err_prev = 1'b0;
  int we_cnt, seen_done;
  logic got_tx;
  logic [7:0] first_tx, last_wdata;
  logic [ADDR_W-1:0] last_addr;
  task automatic chk(input string nm, input int r, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, r, act, exp);
    end
  endtask
  // Expected timeline, in cycles after the accepted start (cycle 0):
  // start_k at s_k (s_0 = 1+CS_SETUP), done_k at s_k+lat_k, write at done_k+1,
  // s_{k+1} = done_k+2, completion at done_last+2+CS_SETUP; n=0 completes at cycle 1.
  task automatic run(input logic [ADDR_W:0] n_in, input logic [7:0] cmd, input bit noise, input bit tmo);
    int ne, s, d, dn, t_end, tmo_at;
    ne = n_in > NMAX ? NMAX : int'(n_in);
    tmo_at = 1000;
    for (int r = 0; r < 256; r++) begin
      exp_cs[r] = 1'b1; exp_start[r] = 1'b0; exp_we[r] = 1'b0; exp_busy[r] = 1'b0;
      exp_done[r] = 1'b0; exp_tx[r] = '0; exp_wd[r] = '0; exp_addr[r] = '0;
      drv_done[r] = 1'b0; drv_ini[r] = 1'b0; drv_rx[r] = '0;
    end
    dn = 1;
    if (ne > 0) begin
      s = 1 + CS_SETUP;
      for (int k = 0; k < ne; k++) begin
        exp_start[s] = 1'b1;
        exp_tx[s] = k == 0 ? cmd : 8'h00;
        if (tmo) begin
          tmo_at = s + TIMEOUT + 1;
          dn = s + TIMEOUT + CS_SETUP + 1;
          break;
        end
        d = s + lat_g[k];
        drv_done[d] = 1'b1; drv_rx[d] = rx_g[k];
        exp_we[d+1] = 1'b1; exp_addr[d+1] = ADDR_W'(k); exp_wd[d+1] = rx_g[k];
        s = d + 2;
        dn = d + 2 + CS_SETUP;
      end
      for (int r = 1; r < dn; r++) exp_cs[r] = 1'b0;
    end
    for (int r = 1; r <= dn; r++) exp_busy[r] = 1'b1;
    exp_done[dn] = 1'b1;
    t_end = dn + 3;
    exp_err[0] = err_prev;
    for (int r = 1; r < 256; r++) exp_err[r] = r >= tmo_at;
    if (noise) begin
      drv_done[1] = 1'b1; drv_rx[1] = 8'hEE;
      drv_ini[2 + CS_SETUP] = 1'b1;
    end
    for (int r = 0; r <= t_end; r++) begin
      @(posedge clk_pi); #1;
      rel = r; chk_on = 1'b1;
      inicio_pi = r == 0 || drv_ini[r];
      n_bytes_pi = r == 0 ? n_in : 3'd1;
      cmd_pi = r == 0 ? cmd : 8'hFF;
      spi_done_pi = drv_done[r];
      spi_rx_pi = drv_done[r] ? drv_rx[r] : 8'h5A;
    end
    @(posedge clk_pi); #1;
    chk_on = 1'b0; inicio_pi = 1'b0; spi_done_pi = 1'b0;
    err_prev = tmo;
  endtask
  always @(negedge clk_pi) if (chk_on) begin
    if (rel == 0) begin we_cnt = 0; seen_done = -1; got_tx = 1'b0; end
    chk("cs", rel, 32'(cs_ctrl_po), 32'(exp_cs[rel]));
    chk("start", rel, 32'(spi_start_po), 32'(exp_start[rel]));
    chk("we", rel, 32'(we_po), 32'(exp_we[rel]));
    chk("busy", rel, 32'(busy_po), 32'(exp_busy[rel]));
    chk("done", rel, 32'(done_po), 32'(exp_done[rel]));
    chk("error", rel, 32'(error_po), 32'(exp_err[rel]));
    if (exp_start[rel]) chk("tx", rel, 32'(spi_tx_po), 32'(exp_tx[rel]));
    if (exp_we[rel]) begin
      chk("addr", rel, 32'(addr_po), 32'(exp_addr[rel]));
      chk("wdata", rel, 32'(wdata_po), 32'(exp_wd[rel]));
    end
    if (done_po) seen_done = rel;
    if (we_po) begin we_cnt++; last_wdata = wdata_po; last_addr = addr_po; end
    if (spi_start_po && !got_tx) begin got_tx = 1'b1; first_tx = spi_tx_po; end
  end
  initial begin
    repeat (3) @(posedge clk_pi);
    #1;
    chk("rst_cs", 0, 32'(cs_ctrl_po), 32'd1);
    chk("rst_busy", 0, 32'(busy_po), 32'd0);
    chk("rst_start", 0, 32'(spi_start_po), 32'd0);
    chk("rst_we", 0, 32'(we_po), 32'd0);
    rst_n_pi = 1'b1;
    repeat (2) @(posedge clk_pi);
    lat_g = '{3, 1, 1, 1}; rx_g = '{8'hA5, 8'h00, 8'h00, 8'h00};
    run(3'd1, 8'h0B, 1'b0, 1'b0);
    chk("n1_done_cycle", 0, 32'(seen_done), 32'd10);
    chk("n1_writes", 0, 32'(we_cnt), 32'd1);
    chk("n1_wdata", 0, 32'(last_wdata), 32'hA5);
    chk("n1_tx", 0, 32'(first_tx), 32'h0B);
    lat_g = '{2, 1, 3, 2}; rx_g = '{8'h11, 8'h22, 8'h33, 8'h44};
    run(3'd4, 8'h0B, 1'b0, 1'b0);
    chk("n4_writes", 0, 32'(we_cnt), 32'd4);
    chk("n4_last_addr", 0, 32'(last_addr), 32'd3);
    chk("n4_last_wdata", 0, 32'(last_wdata), 32'h44);
    run(3'd0, 8'h0B, 1'b0, 1'b0);
    chk("n0_done_cycle", 0, 32'(seen_done), 32'd1);
    chk("n0_writes", 0, 32'(we_cnt), 32'd0);
    lat_g = '{1, 2, 1, 2}; rx_g = '{8'h01, 8'h02, 8'h03, 8'h04};
    run(3'd7, 8'h9F, 1'b0, 1'b0);
    chk("n7_clamped_writes", 0, 32'(we_cnt), 32'd4);
    lat_g = '{3, 2, 1, 1}; rx_g = '{8'hC3, 8'h3C, 8'h00, 8'h00};
    run(3'd2, 8'h03, 1'b1, 1'b0);
    chk("noise_writes", 0, 32'(we_cnt), 32'd2);
    chk("noise_last_addr", 0, 32'(last_addr), 32'd1);
`ifdef SPI_SEQ_TIMEOUT_EN
    run(3'd3, 8'h0B, 1'b0, 1'b1);
    chk("tmo_writes", 0, 32'(we_cnt), 32'd0);
    chk("tmo_done_cycle", 0, 32'(seen_done), 32'd16);
    chk("tmo_error_sticky", 0, 32'(error_po), 32'd1);
    lat_g = '{2, 1, 1, 1}; rx_g = '{8'h77, 8'h00, 8'h00, 8'h00};
    run(3'd1, 8'h0B, 1'b0, 1'b0);
    chk("tmo_error_cleared", 0, 32'(error_po), 32'd0);
`endif
    @(posedge clk_pi); #1;
    inicio_pi = 1'b1; n_bytes_pi = 3'd1; cmd_pi = 8'h0B;
    @(posedge clk_pi); #1;
    inicio_pi = 1'b0;
    repeat (5) @(posedge clk_pi);
    #2;
    chk("pre_rst_cs_low", 0, 32'(cs_ctrl_po), 32'd0);
    rst_n_pi = 1'b0;
    #1;
    chk("midrst_cs", 0, 32'(cs_ctrl_po), 32'd1);
    chk("midrst_busy", 0, 32'(busy_po), 32'd0);
    chk("midrst_start", 0, 32'(spi_start_po), 32'd0);
    chk("midrst_tx", 0, 32'(spi_tx_po), 32'd0);
    chk("midrst_we", 0, 32'(we_po), 32'd0);
    chk("midrst_addr", 0, 32'(addr_po), 32'd0);
    chk("midrst_wdata", 0, 32'(wdata_po), 32'd0);
    chk("midrst_done", 0, 32'(done_po), 32'd0);
    chk("midrst_error", 0, 32'(error_po), 32'd0);
    @(posedge clk_pi); #1;
    rst_n_pi = 1'b1;
    for (int r = 0; r < 8; r++) begin
      @(posedge clk_pi); #1;
      spi_done_pi = r[0];
      spi_rx_pi = 8'hA5;
      #3;
      chk("postrst_cs", r, 32'(cs_ctrl_po), 32'd1);
      chk("postrst_we", r, 32'(we_po), 32'd0);
      chk("postrst_busy", r, 32'(busy_po), 32'd0);
    end
    spi_done_pi = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/spi_secuenciador_ctrl.md
# spi_secuenciador_ctrl

Burst sequencer that drives the SPI master of the peripheral interface. On one start pulse it asserts chip-select, issues `n` back-to-back byte transfers (command byte first, then dummy bytes), and writes every received byte into the result memory at consecutive addresses. It then releases chip-select and reports completion. It sits between the top-level start/debounce logic and the SPI master/memory pair, and owns CS for the whole burst.

## Interface
- `ADDR_W`, 2: memory address width; maximum burst is 2^ADDR_W bytes.
- `CS_SETUP`, 2: cycles CS is held low before the first start pulse and after the last store (≥1).
- `TIMEOUT`, 255: maximum cycles spent waiting for `spi_done_pi` (used only with the timeout feature).

Ports:
- `clk_pi`  in  1  system clock.
- `rst_n_pi`  in  1  asynchronous, active-low reset.
- `inicio_pi`  in  1  burst start request, already synchronous to `clk_pi`.
- `n_bytes_pi`  in  ADDR_W+1  number of bytes in the burst, sampled at start.
- `cmd_pi`  in  8  first byte transmitted, sampled at start.
- `spi_start_po`  out  1  one-cycle start pulse to the SPI master.
- `spi_tx_po`  out  8  byte to transmit, valid while `spi_start_po` is high.
- `spi_done_pi`  in  1  SPI master transfer-complete pulse.
- `spi_rx_pi`  in  8  received byte, valid while `spi_done_pi` is high.
- `cs_ctrl_po`  out  1  chip-select, active-low.
- `we_po`  out  1  memory write strobe (one cycle).
- `addr_po`  out  ADDR_W  memory write address.
- `wdata_po`  out  8  memory write data.
- `busy_po`  out  1  high from the cycle after accepted start until the cycle after DONE.
- `done_po`  out  1  one-cycle burst-complete pulse.
- `error_po`  out  1  sticky timeout flag; cleared on the next accepted start.

## Operation
- All outputs are registered. Reset values: `cs_ctrl_po`=1; all other outputs 0. The FSM resets to IDLE, and the byte index and counters reset to 0.
- States: IDLE, SETUP, START, WAIT, STORE, HOLD, DONE.
- IDLE: `inicio_pi`=1 latches `n_bytes_pi`, `cmd_pi`, and clears `error_po`.
  - `n`=0: go to DONE with no CS activity.
  - `n` > 2^ADDR_W: clamp `n` to 2^ADDR_W.
  - Otherwise go to SETUP with CS low.
- SETUP: runs for CS_SETUP cycles, then goes to START.
- START: `spi_start_po`=1 for one cycle. `spi_tx_po`=cmd when idx=0, else 8'h00. Then go to WAIT.
- WAIT: on `spi_done_pi`=1, capture `spi_rx_pi` and go to STORE. `spi_done_pi` is ignored in every other state.
- STORE: `we_po`=1, `addr_po`=idx, `wdata_po`=captured byte.
  - If idx = n−1: go to HOLD.
  - Else: idx++ and go to START.
- HOLD: runs for CS_SETUP cycles with CS still low, then goes to DONE.
- DONE: `cs_ctrl_po`=1, `done_po`=1 for one cycle, then go to IDLE.
- `inicio_pi` outside IDLE is ignored.
- Reset mid-burst: CS rises immediately (asynchronously), no write occurs, and the partial burst is abandoned.

## Timing
- Start accepted at cycle 0. CS low and busy high at cycle 1. First `spi_start_po` at cycle 1+CS_SETUP.
- `spi_done_pi` at cycle d produces `we_po` at d+1. The next `spi_start_po` for a following byte is at d+2.
- For the last byte: `done_po` and CS high at d+2+CS_SETUP. `busy_po` falls one cycle later.
- `n`=0: `done_po` at cycle 1, `busy_po` high only in cycle 1.
- `spi_done_pi` coinciding with `spi_start_po` is not accepted.

## Configuration
- `SPI_SEQ_TIMEOUT_EN` defined:
  - WAIT counts cycles. On reaching TIMEOUT without `spi_done_pi`, set `error_po`, skip the write, and go to HOLD. DONE still pulses.
  - Remaining bytes are not transferred.
- Undefined: WAIT waits indefinitely, and `error_po` is tied 0.

## Structure
- Package `spi_seq_pkg` holds:
  - the state enum `spi_seq_state_t`;
  - `SPI_SEQ_DUMMY` = 8'h00.
- One sub-module, `spi_seq_contador`: a loadable down-counter with a zero flag. It is reused for SETUP/HOLD and, under the macro, for the WAIT timeout.

## Test plan
- Reset asserted mid-WAIT → `cs_ctrl_po`=1 and all other outputs 0 immediately. After release, remains in IDLE with no write.
- `n`=1, cmd=8'h0B, master returns 8'hA5 → `spi_tx_po`=8'h0B at start, one write at addr 0 with 8'hA5, and a single `done_po` pulse at d+2+CS_SETUP.
- `n`=4, rx 8'h11/22/33/44 → tx 0B,00,00,00; writes at addresses 0–3 with 11,22,33,44; CS low continuously throughout.
- `n`=0, then `n`=7 (ADDR_W=2) → `done_po` at cycle 1 with no CS activity; then exactly 4 transfers (clamped).
- `inicio_pi` pulsed during WAIT, and `spi_done_pi` pulsed during SETUP → both ignored; byte count and addresses unchanged.
- With the macro, TIMEOUT=10 and no `spi_done_pi` → `error_po`=1 and no write. `done_po` fires. `error_po` clears on the next start.
